// File: rtl/result_collector_if.sv
// Handshake bundle for result_collector: serial product input, word output
// stream and status/flag signals.
interface result_collector_if #(
   parameter int W = 32
);
   logic         po;
   logic         bit_vld;
   logic         sof;
   logic         clr;
   logic [W-1:0] res;
   logic         res_vld;
   logic         res_rdy;
   logic         busy;
   logic         frame_err;
   logic         ovf;
   logic [7:0]   word_cnt;

   modport master (
      output po, bit_vld, sof, clr, res_rdy,
      input  res, res_vld, busy, frame_err, ovf, word_cnt
   );

   modport slave (
      input  po, bit_vld, sof, clr, res_rdy,
      output res, res_vld, busy, frame_err, ovf, word_cnt
   );
endinterface

// File: rtl/result_collector.sv
// Deserialises MSB-first product bits from the systolic array into W-bit
// words and queues them in a small FIFO with sticky error flags.
module result_collector #(
   parameter int W     = 32,
   parameter int DEPTH = 2
) (
   input  logic              clk,
   input  logic              rst,
   result_collector_if.slave bus
);
   localparam int CW = $clog2(W + 1);
   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] DEPTH_C = (PW + 1)'(DEPTH);

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

   logic [1:0]    rst_sync_r;
   logic          rst_n_s;
   state_t        state_r, state_nxt_s;
   logic [W-1:0]  sreg_r, sreg_nxt_s, word_s;
   logic [CW-1:0] cnt_r, cnt_nxt_s;
   logic          push_s, frame_err_set_s;
   logic          pop_s, full_s, wr_en_s, ovf_set_s;
   logic [W-1:0]  mem_r [DEPTH];
   logic [PW-1:0] wr_ptr_r, rd_ptr_r;
   logic [PW:0]   count_r, count_nxt_s;
   logic          res_vld_r, frame_err_r, ovf_r;
   logic [7:0]    word_cnt_r;

   // Reset synchroniser: assert immediately, release after two clock edges
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rst_sync_r <= 2'b00;
      end else begin
         rst_sync_r <= {rst_sync_r[0], 1'b1};
      end
   end

   assign rst_n_s = rst_sync_r[1];

   // FSM state register
   always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state and shift/count datapath; a sof in COLLECT restarts the frame
   always_comb begin
      state_nxt_s     = state_r;
      sreg_nxt_s      = sreg_r;
      cnt_nxt_s       = cnt_r;
      push_s          = 1'b0;
      frame_err_set_s = 1'b0;
      word_s          = {sreg_r[W-2:0], bus.po};
      case (state_r)
         IDLE: begin
            if (bus.bit_vld && bus.sof) begin
               sreg_nxt_s  = {{(W-1){1'b0}}, bus.po};
               cnt_nxt_s   = CW'(1);
               state_nxt_s = COLLECT;
            end else begin
               state_nxt_s = IDLE;
            end
         end
         COLLECT: begin
            if (bus.bit_vld && bus.sof) begin
               sreg_nxt_s      = {{(W-1){1'b0}}, bus.po};
               cnt_nxt_s       = CW'(1);
               frame_err_set_s = 1'b1;
               state_nxt_s     = COLLECT;
            end else if (bus.bit_vld && (cnt_r == CW'(W - 1))) begin
               sreg_nxt_s  = word_s;
               cnt_nxt_s   = CW'(0);
               push_s      = 1'b1;
               state_nxt_s = IDLE;
            end else if (bus.bit_vld) begin
               sreg_nxt_s  = word_s;
               cnt_nxt_s   = cnt_r + CW'(1);
               state_nxt_s = COLLECT;
            end else begin
               state_nxt_s = COLLECT;
            end
         end
         default: begin
            state_nxt_s = IDLE;
         end
      endcase
   end

   // Shift register and bit counter
   always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         sreg_r <= '0;
         cnt_r  <= '0;
      end else begin
         sreg_r <= sreg_nxt_s;
         cnt_r  <= cnt_nxt_s;
      end
   end

   assign pop_s     = res_vld_r & bus.res_rdy;
   assign full_s    = (count_r == DEPTH_C);
   assign wr_en_s   = push_s & (~full_s | pop_s);
   assign ovf_set_s = push_s & full_s & ~pop_s;

   // FIFO occupancy update
   always_comb begin
      count_nxt_s = count_r;
      case ({wr_en_s, pop_s})
         2'b10:   count_nxt_s = count_r + (PW + 1)'(1);
         2'b01:   count_nxt_s = count_r - (PW + 1)'(1);
         default: count_nxt_s = count_r;
      endcase
   end

   // FIFO storage, pointers and registered valid
   always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
         wr_ptr_r  <= '0;
         rd_ptr_r  <= '0;
         count_r   <= '0;
         res_vld_r <= 1'b0;
      end else begin
         if (wr_en_s) begin
            mem_r[wr_ptr_r] <= word_s;
            wr_ptr_r        <= wr_ptr_r + PW'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + PW'(1);
         end
         count_r   <= count_nxt_s;
         res_vld_r <= (count_nxt_s != '0);
      end
   end

   // Sticky flags and pop counter; a setting event outranks clr
   always_ff @(posedge clk or negedge rst_n_s) begin
      if (!rst_n_s) begin
         frame_err_r <= 1'b0;
         ovf_r       <= 1'b0;
         word_cnt_r  <= 8'd0;
      end else begin
         frame_err_r <= frame_err_set_s | (frame_err_r & ~bus.clr);
         ovf_r       <= ovf_set_s | (ovf_r & ~bus.clr);
         if (bus.clr) begin
            word_cnt_r <= 8'd0;
         end else if (pop_s) begin
            word_cnt_r <= word_cnt_r + 8'd1;
         end else begin
            word_cnt_r <= word_cnt_r;
         end
      end
   end

   assign bus.res       = mem_r[rd_ptr_r];
   assign bus.res_vld   = res_vld_r;
   assign bus.busy      = (state_r == COLLECT);
   assign bus.frame_err = frame_err_r;
   assign bus.ovf       = ovf_r;
   assign bus.word_cnt  = word_cnt_r;
endmodule

// File: tb/tb_result_collector.sv
// Self-checking bench for result_collector: table of frames plus hand-written
// sequences for FIFO-full, clr, restart and reset corner cases.
module tb_result_collector;
   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   result_collector_if #(.W(32)) bus ();

   result_collector #(.W(32), .DEPTH(2)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] data;
      logic        toggle;
      logic [7:0]  exp_cnt;
   } vec_t;

   vec_t        tbl [4];
   logic [31:0] exp_q [$];
   int          n_vec = 0;
   int          n_err = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // One clock: scoreboard pop at negedge, then return just after posedge
   task automatic tick();
      logic [31:0] e;
      @(negedge clk);
      if (rst && bus.res_vld && bus.res_rdy) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL res_unexpected: got %h expected none", bus.res);
         end else begin
            e = exp_q.pop_front();
            check("res_order", 64'(bus.res), 64'(e));
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [31:0] data, input logic toggle,
                             input logic rdy_last, input logic clr_last);
      for (int i = 31; i >= 0; i--) begin
         bus.po      = data[i];
         bus.bit_vld = 1'b1;
         bus.sof     = (i == 31);
         if (i == 0 && rdy_last) bus.res_rdy = 1'b1;
         if (i == 0 && clr_last) bus.clr = 1'b1;
         tick();
         bus.clr = 1'b0;
         if (i == 0 && rdy_last) bus.res_rdy = 1'b0;
         if (toggle && i != 0) begin
            bus.bit_vld = 1'b0;
            bus.sof     = 1'b1;
            bus.po      = 1'($urandom);
            tick();
         end
      end
      bus.bit_vld = 1'b0;
      bus.sof     = 1'b0;
   endtask

   task automatic send_bits(input logic [31:0] data, input int n);
      for (int i = 0; i < n; i++) begin
         bus.po      = data[31-i];
         bus.bit_vld = 1'b1;
         bus.sof     = (i == 0);
         tick();
      end
      bus.bit_vld = 1'b0;
      bus.sof     = 1'b0;
   endtask

   initial begin
      tbl[0] = '{32'hA5A50F0F, 1'b0, 8'd1};
      tbl[1] = '{32'hCAFEF00D, 1'b1, 8'd2};
      tbl[2] = '{32'h00000000, 1'b0, 8'd3};
      tbl[3] = '{32'hFFFFFFFF, 1'b1, 8'd4};

      rst = 1'b0;
      bus.po = 1'b0; bus.bit_vld = 1'b0; bus.sof = 1'b0;
      bus.clr = 1'b0; bus.res_rdy = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_res", 64'(bus.res), 64'd0);
      check("rst_res_vld", 64'(bus.res_vld), 64'd0);
      check("rst_busy", 64'(bus.busy), 64'd0);
      check("rst_flags", 64'({bus.frame_err, bus.ovf}), 64'd0);
      check("rst_word_cnt", 64'(bus.word_cnt), 64'd0);

      // Table: single frames with consumer always ready
      bus.res_rdy = 1'b1;
      for (int v = 0; v < 4; v++) begin
         send_frame(tbl[v].data, tbl[v].toggle, 1'b0, 1'b0);
         exp_q.push_back(tbl[v].data);
         check("lat_vld", 64'(bus.res_vld), 64'd1);
         check("lat_res", 64'(bus.res), 64'(tbl[v].data));
         check("idle_busy", 64'(bus.busy), 64'd0);
         tick();
         check("tbl_vld_drop", 64'(bus.res_vld), 64'd0);
         check("tbl_word_cnt", 64'(bus.word_cnt), 64'(tbl[v].exp_cnt));
      end

      // Back-to-back frames into a stalled FIFO, then overflow
      bus.res_rdy = 1'b0;
      send_frame(32'h00000001, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(32'h00000001);
      send_frame(32'h80000000, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(32'h80000000);
      check("full_head", 64'(bus.res), 64'h00000001);
      check("full_no_ovf", 64'(bus.ovf), 64'd0);
      tick(); tick();
      check("hold_head", 64'(bus.res), 64'h00000001);
      send_frame(32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
      check("ovf_set", 64'(bus.ovf), 64'd1);
      check("ovf_head", 64'(bus.res), 64'h00000001);
      bus.res_rdy = 1'b1;
      tick();
      check("ovf_second", 64'(bus.res), 64'h80000000);
      tick();
      check("drain_vld", 64'(bus.res_vld), 64'd0);
      check("drain_cnt", 64'(bus.word_cnt), 64'd6);
      bus.res_rdy = 1'b0;

      bus.clr = 1'b1;
      tick();
      bus.clr = 1'b0;
      check("clr_ovf", 64'(bus.ovf), 64'd0);
      check("clr_cnt", 64'(bus.word_cnt), 64'd0);

      // Push and pop together while full
      send_frame(32'h11111111, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(32'h11111111);
      send_frame(32'h22222222, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(32'h22222222);
      send_frame(32'h33333333, 1'b0, 1'b1, 1'b0);
      exp_q.push_back(32'h33333333);
      check("pushpop_ovf", 64'(bus.ovf), 64'd0);
      check("pushpop_head", 64'(bus.res), 64'h22222222);
      check("pushpop_cnt", 64'(bus.word_cnt), 64'd1);
      bus.res_rdy = 1'b1;
      tick(); tick();
      check("pushpop_drain", 64'(bus.res_vld), 64'd0);
      check("pushpop_cnt2", 64'(bus.word_cnt), 64'd3);
      bus.res_rdy = 1'b0;

      // clr in the same cycle as an overflow, then clr with a pop
      send_frame(32'hAAAA5555, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(32'hAAAA5555);
      send_frame(32'h5555AAAA, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(32'h5555AAAA);
      send_frame(32'h0F0F0F0F, 1'b0, 1'b0, 1'b1);
      check("clr_ovf_wins", 64'(bus.ovf), 64'd1);
      check("clr_ovf_cnt", 64'(bus.word_cnt), 64'd0);
      bus.res_rdy = 1'b1;
      bus.clr = 1'b1;
      tick();
      bus.clr = 1'b0;
      check("clr_pop_cnt", 64'(bus.word_cnt), 64'd0);
      check("clr_pop_ovf", 64'(bus.ovf), 64'd0);
      tick();
      check("clr_pop_cnt2", 64'(bus.word_cnt), 64'd1);
      check("clr_pop_vld", 64'(bus.res_vld), 64'd0);

      // Frame restart after 10 bits
      bus.clr = 1'b1;
      tick();
      bus.clr = 1'b0;
      send_bits(32'h13579BDF, 10);
      send_frame(32'h12345678, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(32'h12345678);
      check("restart_err", 64'(bus.frame_err), 64'd1);
      check("restart_res", 64'(bus.res), 64'h12345678);
      tick();
      check("restart_one_word", 64'(bus.word_cnt), 64'd1);
      check("restart_q_empty", 64'(exp_q.size()), 64'd0);

      // Reset mid-frame with a queued word
      bus.res_rdy = 1'b0;
      send_frame(32'h01020304, 1'b0, 1'b0, 1'b0);
      send_bits(32'h0BADF00D, 20);
      check("pre_rst_busy", 64'(bus.busy), 64'd1);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_res", 64'(bus.res), 64'd0);
      check("mid_rst_vld_busy", 64'({bus.res_vld, bus.busy}), 64'd0);
      check("mid_rst_flags", 64'({bus.frame_err, bus.ovf}), 64'd0);
      check("mid_rst_cnt", 64'(bus.word_cnt), 64'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      for (int i = 0; i < 12; i++) begin
         bus.po      = 1'($urandom);
         bus.bit_vld = 1'b1;
         bus.sof     = 1'b0;
         tick();
      end
      bus.bit_vld = 1'b0;
      check("trail_busy", 64'(bus.busy), 64'd0);
      check("trail_vld", 64'(bus.res_vld), 64'd0);
      bus.res_rdy = 1'b1;
      send_frame(32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
      exp_q.push_back(32'hDEADBEEF);
      check("post_rst_res", 64'(bus.res), 64'hDEADBEEF);
      tick();
      check("post_rst_cnt", 64'(bus.word_cnt), 64'd1);
      check("post_rst_err", 64'(bus.frame_err), 64'd0);
      check("final_q_empty", 64'(exp_q.size()), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 Parameter W, default 32: field/product width in bits; must be 2 to 64.
REQ-002 Parameter DEPTH, default 2: output FIFO entries; must be 2 or 4.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  asynchronous, active-low reset; asserts immediately, releases synchronously to clk.
REQ-005 po  input  1  serial product bit from last systolic cell, MSB first.
REQ-006 bit_vld  input  1  qualifies po/sof this cycle.
REQ-007 sof  input  1  start of frame; marks the MSB of a new product word; meaningful only with bit_vld=1.
REQ-008 clr  input  1  synchronous clear of sticky flags and word_cnt.
REQ-009 res  output  W  head-of-FIFO product word.
REQ-010 res_vld  output  1  FIFO non-empty.
REQ-011 res_rdy  input  1  consumer accepts res when res_vld=1 and res_rdy=1.
REQ-012 busy  output  1  frame assembly in progress (state COLLECT).
REQ-013 frame_err  output  1  sticky: frame restarted or aborted before completion.
REQ-014 ovf  output  1  sticky: completed word dropped because FIFO full.
REQ-015 word_cnt  output  8  count of words popped by consumer, modulo 256.

Function
REQ-016 Accept = bit_vld=1; no state changes on cycles with bit_vld=0 except FIFO pop and clr.
REQ-017 FSM states IDLE and COLLECT; busy=1 exactly in COLLECT.
REQ-018 IDLE: accepted bit with sof=1 -> shift register <= {0..., po}, bit counter <= 1, go COLLECT; accepted bit with sof=0 ignored, no flag.
REQ-019 COLLECT: accepted bit with sof=0 -> shift register <= {sreg[W-2:0], po}, counter +1.
REQ-020 COLLECT: accepted bit with sof=1 -> partial word discarded, frame_err set, new frame started as in REQ-018 (counter <= 1, stay COLLECT).
REQ-021 Word complete when the W-th bit is accepted: the assembled word {sreg[W-2:0], po} is pushed to the FIFO at that edge, counter <= 0, go IDLE.
REQ-022 Latency: res_vld rises in the cycle following the edge that accepted the last (LSB) bit, when the FIFO was empty.
REQ-023 If a bit with sof=1 arrives on the cycle after completion it is taken in IDLE; back-to-back frames have no bubble.
REQ-024 FIFO: first-in first-out; pop on res_vld and res_rdy; res holds the head entry stable while res_vld=1 and res_rdy=0.
REQ-025 Simultaneous push and pop when full: both occur, occupancy unchanged, no ovf.
REQ-026 Push when full without pop: word dropped, FIFO contents unchanged, ovf set.
REQ-027 Simultaneous push and pop when empty: word enters FIFO; the pop has no effect because res_vld=0 that cycle.
REQ-028 word_cnt increments by 1 per pop and wraps 255 -> 0.
REQ-029 clr=1: frame_err, ovf, word_cnt <= 0 at the edge; a flag-setting event in the same cycle wins over clr (flag reads 1); a pop in the same cycle leaves word_cnt = 0.
REQ-030 clr does not affect the FSM, the shift register or the FIFO.

Reset
REQ-031 rst=0: state IDLE; counter, shift register and FIFO pointers zero; res=0, res_vld=0, busy=0, frame_err=0, ovf=0, word_cnt=0.
REQ-032 rst asserted mid-frame or with the FIFO non-empty discards all data; no flag is set by reset.

Verification
REQ-033 W=32, res_rdy=1, 32 bits of 0xA5A50F0F MSB first, sof on the first bit -> res_vld=1 for one cycle, res=0xA5A50F0F, one cycle after the LSB edge; word_cnt=1.
REQ-034 Two back-to-back frames 0x00000001 and 0x80000000, res_rdy=0 -> FIFO holds both; raising res_rdy yields them in order over two cycles; ovf=0.
REQ-035 Third frame 0xFFFFFFFF while the FIFO is full and res_rdy=0 -> ovf=1 and the FIFO still yields 0x00000001 then 0x80000000.
REQ-036 sof re-asserted after 10 bits, then a full 32-bit frame 0x12345678 -> frame_err=1, res=0x12345678, exactly one word delivered.
REQ-037 rst pulsed low at bit 20 of a frame -> all outputs zero at once; 12 trailing bits without sof are ignored; the next sof frame 0xDEADBEEF is delivered correctly.
REQ-038 bit_vld toggling 1/0 on alternate cycles during 0xCAFEF00D -> correct word; clr together with an overflow event -> ovf reads 1.
